// File: rtl/cog_line_point_extractor.sv
// Thresholded run finder on an AXI-Stream video line; emits per-run start,
// sum(I) and sum(I*x) plus frame/line strobes aligned behind the points.
module cog_line_point_extractor #(
    parameter int DATA_WIDTH   = 8,
    parameter int IMG_WIDTH    = 2048,
    parameter int FRAME_HEIGHT = 1024,
    parameter int MIN_RUN      = 2,
    parameter int MAX_RUN      = 64
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] i_threshold,
    output logic [29:0]           o_sum_of_I_mult_coord,
    output logic [22:0]           o_sum_of_I,
    output logic [10:0]           o_start_point,
    output logic                  o_point_is_valid,
    output logic                  o_end_of_line_delayed,
    output logic                  o_end_of_frame_delayed,
    output logic                  o_new_frame_delayed,
    output logic                  o_line_err
);

    localparam int XW  = 11;
    localparam int YW  = 16;
    localparam int LW  = 12;
    localparam int SIW = 23;
    localparam int SXW = 30;

    localparam logic [XW-1:0] X_MAX   = '1;
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(FRAME_HEIGHT - 1);
    localparam logic [LW-1:0] LEN_MIN = LW'(MIN_RUN);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_RUN);

    typedef enum logic [1:0] {
        WAIT_SOF,
        GAP,
        RUN
    } state_t;

    state_t         state_q, state_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic [XW-1:0]  start_q, start_d;
    logic [SIW-1:0] sum_i_q, sum_i_d;
    logic [SXW-1:0] sum_ix_q, sum_ix_d;
    logic [LW-1:0]  len_q, len_d;
    logic           tready_q;

    logic           beat, active, hot;
    state_t         eff;
    logic [XW-1:0]  x_beat;
    logic [YW-1:0]  y_beat;
    logic [18:0]    pix_x;
    logic [XW-1:0]  run_start;
    logic [SIW-1:0] run_i;
    logic [SXW-1:0] run_ix;
    logic [LW-1:0]  run_len;

    logic           close;
    logic [XW-1:0]  c_start;
    logic [SIW-1:0] c_i;
    logic [SXW-1:0] c_ix;
    logic [LW-1:0]  c_len;
    logic           qualify;

    logic           p1_vld_q, eol1_q, eof1_q, nf_q, lerr_q;
    logic [XW-1:0]  p1_start_q;
    logic [SIW-1:0] p1_i_q;
    logic [SXW-1:0] p1_ix_q;
    logic           pv_q, eol2_q, eof2_q, eol3_q, eof3_q;
    logic [XW-1:0]  start_o_q;
    logic [SIW-1:0] sum_i_o_q;
    logic [SXW-1:0] sum_ix_o_q;

    assign beat   = s_axis_tvalid & tready_q;
    assign active = beat & (s_axis_tuser | (state_q != WAIT_SOF));
    assign hot    = s_axis_tdata >= i_threshold;
    // A tuser beat restarts the frame: any open run is abandoned.
    assign eff    = s_axis_tuser ? GAP : state_q;
    assign x_beat = s_axis_tuser ? '0 : x_q;
    assign y_beat = s_axis_tuser ? '0 : y_q;
    assign pix_x  = 19'(s_axis_tdata) * 19'(x_beat);

    assign run_start = (eff == RUN) ? start_q : x_beat;
    assign run_i     = ((eff == RUN) ? sum_i_q : '0) + SIW'(s_axis_tdata);
    assign run_ix    = ((eff == RUN) ? sum_ix_q : '0) + SXW'(pix_x);
    assign run_len   = (eff != RUN) ? LW'(1) :
                       (&len_q)     ? len_q  : len_q + LW'(1);

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        start_d  = start_q;
        sum_i_d  = sum_i_q;
        sum_ix_d = sum_ix_q;
        len_d    = len_q;
        close    = 1'b0;
        c_start  = start_q;
        c_i      = sum_i_q;
        c_ix     = sum_ix_q;
        c_len    = len_q;
        if (active) begin
            x_d = s_axis_tlast       ? '0     :
                  (x_beat == X_MAX) ? x_beat : x_beat + XW'(1);
            y_d = y_beat + YW'(s_axis_tlast);
            state_d = GAP;
            if (hot) begin
                start_d  = run_start;
                sum_i_d  = run_i;
                sum_ix_d = run_ix;
                len_d    = run_len;
            end
            unique case (1'b1)
                hot && s_axis_tlast: begin
                    close   = 1'b1;
                    c_start = run_start;
                    c_i     = run_i;
                    c_ix    = run_ix;
                    c_len   = run_len;
                end
                hot && !s_axis_tlast: state_d = RUN;
                !hot && (eff == RUN): close = 1'b1;
                default: ;
            endcase
        end
    end

    assign qualify = close && (c_len >= LEN_MIN) && (c_len <= LEN_MAX);

    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            state_q  <= WAIT_SOF;
            x_q      <= '0;
            y_q      <= '0;
            start_q  <= '0;
            sum_i_q  <= '0;
            sum_ix_q <= '0;
            len_q    <= '0;
            tready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            start_q  <= start_d;
            sum_i_q  <= sum_i_d;
            sum_ix_q <= sum_ix_d;
            len_q    <= len_d;
            tready_q <= 1'b1;
        end
    end

    // Points land at N+2; EOL/EOF trail one cycle later so they follow the points.
    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            p1_vld_q   <= 1'b0;
            p1_start_q <= '0;
            p1_i_q     <= '0;
            p1_ix_q    <= '0;
            eol1_q     <= 1'b0;
            eof1_q     <= 1'b0;
            nf_q       <= 1'b0;
            lerr_q     <= 1'b0;
            pv_q       <= 1'b0;
            start_o_q  <= '0;
            sum_i_o_q  <= '0;
            sum_ix_o_q <= '0;
            eol2_q     <= 1'b0;
            eof2_q     <= 1'b0;
            eol3_q     <= 1'b0;
            eof3_q     <= 1'b0;
        end else begin
            p1_vld_q   <= qualify;
            p1_start_q <= c_start;
            p1_i_q     <= c_i;
            p1_ix_q    <= c_ix;
            eol1_q     <= active & s_axis_tlast;
            eof1_q     <= active & s_axis_tlast & (y_beat == Y_LAST);
            nf_q       <= beat & s_axis_tuser;
            lerr_q     <= active & s_axis_tlast & (x_beat != X_LAST);
            pv_q       <= p1_vld_q;
            if (p1_vld_q) begin
                start_o_q  <= p1_start_q;
                sum_i_o_q  <= p1_i_q;
                sum_ix_o_q <= p1_ix_q;
            end
            eol2_q     <= eol1_q;
            eof2_q     <= eof1_q;
            eol3_q     <= eol2_q;
            eof3_q     <= eof2_q;
        end
    end

    assign s_axis_tready          = tready_q;
    assign o_point_is_valid       = pv_q;
    assign o_start_point          = start_o_q;
    assign o_sum_of_I             = sum_i_o_q;
    assign o_sum_of_I_mult_coord  = sum_ix_o_q;
    assign o_end_of_line_delayed  = eol3_q;
    assign o_end_of_frame_delayed = eof3_q;
    assign o_new_frame_delayed    = nf_q;
    assign o_line_err             = lerr_q;

endmodule

// File: tb/tb_cog_line_point_extractor.sv
// Randomized line/frame stimulus against a segment-scanning reference model
// of the run extractor; expectations are scheduled per cycle.
module tb_cog_line_point_extractor;

    localparam int DW   = 8;
    localparam int IW   = 16;
    localparam int FH   = 4;
    localparam int MINR = 2;
    localparam int MAXR = 8;
    localparam int MAXC = 20000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tuser;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [DW-1:0] i_threshold;
    logic [29:0]   o_sum_of_I_mult_coord;
    logic [22:0]   o_sum_of_I;
    logic [10:0]   o_start_point;
    logic          o_point_is_valid;
    logic          o_end_of_line_delayed;
    logic          o_end_of_frame_delayed;
    logic          o_new_frame_delayed;
    logic          o_line_err;

    always #5 clk = ~clk;

    cog_line_point_extractor #(
        .DATA_WIDTH  (DW),
        .IMG_WIDTH   (IW),
        .FRAME_HEIGHT(FH),
        .MIN_RUN     (MINR),
        .MAX_RUN     (MAXR)
    ) dut (
        .i_sys_clk             (clk),
        .i_sys_aresetn         (rst_n),
        .s_axis_tdata          (s_axis_tdata),
        .s_axis_tvalid         (s_axis_tvalid),
        .s_axis_tuser          (s_axis_tuser),
        .s_axis_tlast          (s_axis_tlast),
        .s_axis_tready         (s_axis_tready),
        .i_threshold           (i_threshold),
        .o_sum_of_I_mult_coord (o_sum_of_I_mult_coord),
        .o_sum_of_I            (o_sum_of_I),
        .o_start_point         (o_start_point),
        .o_point_is_valid      (o_point_is_valid),
        .o_end_of_line_delayed (o_end_of_line_delayed),
        .o_end_of_frame_delayed(o_end_of_frame_delayed),
        .o_new_frame_delayed   (o_new_frame_delayed),
        .o_line_err            (o_line_err)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit in_frame = 1'b0;
    int y_m   = 0;

    bit e_pv[MAXC];
    bit e_eol[MAXC];
    bit e_eof[MAXC];
    bit e_nf[MAXC];
    bit e_lerr[MAXC];
    int e_st[MAXC];
    int e_si[MAXC];
    int e_six[MAXC];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < MAXC; i++) begin
            e_pv[i] = 0; e_eol[i] = 0; e_eof[i] = 0;
            e_nf[i] = 0; e_lerr[i] = 0;
            e_st[i] = 0; e_si[i] = 0; e_six[i] = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (cyc >= MAXC - 4) begin
            $display("FAIL budget: cycle %0d reached limit %0d", cyc, MAXC - 4);
            $fatal(1, "cycle budget exhausted");
        end
        check("nf", 32'(o_new_frame_delayed), 32'(e_nf[cyc]));
        check("pv", 32'(o_point_is_valid), 32'(e_pv[cyc]));
        check("eol", 32'(o_end_of_line_delayed), 32'(e_eol[cyc]));
        check("eof", 32'(o_end_of_frame_delayed), 32'(e_eof[cyc]));
        check("lerr", 32'(o_line_err), 32'(e_lerr[cyc]));
        if (e_pv[cyc]) begin
            check("start", 32'(o_start_point), e_st[cyc]);
            check("sumI", 32'(o_sum_of_I), e_si[cyc]);
            check("sumIx", 32'(o_sum_of_I_mult_coord), e_six[cyc]);
        end
        e_pv[cyc] = 0; e_eol[cyc] = 0; e_eof[cyc] = 0;
        e_nf[cyc] = 0; e_lerr[cyc] = 0;
    endtask

    task automatic idle();
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = DW'($urandom);
        s_axis_tuser  = 1'($urandom);
        s_axis_tlast  = 1'($urandom);
        i_threshold   = DW'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_exp();
        in_frame = 1'b0;
        y_m = 0;
        idle();
        step();
        step();
        check("tready_rst", 32'(s_axis_tready), 0);
        check("start_rst", 32'(o_start_point), 0);
        check("sumI_rst", 32'(o_sum_of_I), 0);
        check("sumIx_rst", 32'(o_sum_of_I_mult_coord), 0);
        rst_n = 1'b1;
        step();
        check("tready", 32'(s_axis_tready), 1);
    endtask

    // Reference: runs are maximal hot segments of the line; a run closes on
    // the first cold pixel after it, or on its own last pixel if that has tlast.
    task automatic send_line(input int pix[$], input int th[$],
                             input bit usr, input bit lst);
        int L, i, a, b, cb, si, six, c;
        bit act;
        bit cq[$];
        int cs[$], ci[$], cx[$];
        L = pix.size();
        act = in_frame || usr;
        if (usr) begin
            in_frame = 1'b1;
            y_m = 0;
        end
        for (int k = 0; k < L; k++) begin
            cq.push_back(0); cs.push_back(0);
            ci.push_back(0); cx.push_back(0);
        end
        i = 0;
        while (i < L) begin
            if (pix[i] >= th[i]) begin
                a = i;
                while (i < L && pix[i] >= th[i]) i++;
                b = i - 1;
                cb = (b == L - 1) ? (lst ? b : -1) : b + 1;
                if (cb >= 0 && b - a + 1 >= MINR && b - a + 1 <= MAXR) begin
                    si = 0;
                    six = 0;
                    for (int k = a; k <= b; k++) begin
                        si += pix[k];
                        six += pix[k] * k;
                    end
                    cq[cb] = 1; cs[cb] = a; ci[cb] = si; cx[cb] = six;
                end
            end else begin
                i++;
            end
        end
        for (int k = 0; k < L; k++) begin
            while ($urandom_range(3) == 0) begin
                idle();
                step();
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = DW'(pix[k]);
            i_threshold   = DW'(th[k]);
            s_axis_tuser  = usr && (k == 0);
            s_axis_tlast  = lst && (k == L - 1);
            c = cyc + 1;
            if (act) begin
                if (usr && k == 0) e_nf[c] = 1;
                if (cq[k]) begin
                    e_pv[c + 1] = 1;
                    e_st[c + 1] = cs[k];
                    e_si[c + 1] = ci[k];
                    e_six[c + 1] = cx[k];
                end
                if (lst && k == L - 1) begin
                    e_eol[c + 2] = 1;
                    if (y_m == FH - 1) e_eof[c + 2] = 1;
                    if (L - 1 != IW - 1) e_lerr[c] = 1;
                end
            end
            step();
        end
        idle();
        if (act && lst) y_m++;
    endtask

    task automatic rand_line(input int L, output int pix[$], output int th[$]);
        bit h;
        int t;
        pix = {};
        th = {};
        h = 1'($urandom);
        for (int k = 0; k < L; k++) begin
            if ($urandom_range(9) < 3) h = !h;
            t = int'($urandom_range(1, 255));
            th.push_back(t);
            if (h) pix.push_back(int'($urandom_range(t, 255)));
            else   pix.push_back(int'($urandom_range(0, t - 1)));
        end
    endtask

    task automatic zero_line(input int L, output int pix[$], output int th[$]);
        pix = {};
        th = {};
        for (int k = 0; k < L; k++) begin
            pix.push_back(0);
            th.push_back(100);
        end
    endtask

    initial begin
        int pix[$];
        int th[$];
        int nl, L;
        bit lst;
        idle();
        do_reset();

        zero_line(IW, pix, th);
        pix[2] = 200; pix[3] = 150;
        send_line(pix, th, 1, 1);
        zero_line(IW, pix, th);
        pix[5] = 200;
        send_line(pix, th, 0, 1);
        check("spec_start0", 32'(o_start_point), 2);
        check("spec_sumI0", 32'(o_sum_of_I), 350);
        check("spec_sumIx0", 32'(o_sum_of_I_mult_coord), 850);
        zero_line(IW, pix, th);
        pix[14] = 120; pix[15] = 130;
        send_line(pix, th, 0, 1);
        zero_line(IW, pix, th);
        pix[1] = 110; pix[2] = 120; pix[4] = 200; pix[5] = 255;
        send_line(pix, th, 0, 1);
        repeat (3) step();
        check("spec_start3", 32'(o_start_point), 4);
        check("spec_sumI3", 32'(o_sum_of_I), 455);
        check("spec_sumIx3", 32'(o_sum_of_I_mult_coord), 2075);

        zero_line(IW, pix, th);
        for (int k = 3; k <= 12; k++) pix[k] = 200;
        send_line(pix, th, 1, 1);
        zero_line(6, pix, th);
        pix[3] = 200; pix[4] = 200; pix[5] = 200;
        send_line(pix, th, 0, 0);
        zero_line(1, pix, th);
        pix[0] = 200;
        send_line(pix, th, 1, 1);

        for (int f = 0; f < 25; f++) begin
            nl = int'($urandom_range(1, 5));
            for (int j = 0; j < nl; j++) begin
                L = ($urandom_range(6) == 0) ? int'($urandom_range(2, 20)) : IW;
                lst = !(j == nl - 1 && $urandom_range(4) == 0);
                rand_line(L, pix, th);
                send_line(pix, th, j == 0, lst);
            end
        end

        zero_line(8, pix, th);
        for (int k = 2; k < 8; k++) pix[k] = 200;
        send_line(pix, th, 1, 0);
        do_reset();
        rand_line(10, pix, th);
        send_line(pix, th, 0, 1);
        rand_line(10, pix, th);
        send_line(pix, th, 1, 1);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
